leitor_caminho_anterior: RTL and testbench
==========================================

// Module: leitor_caminho_anterior
// PURPOSE
//  Reader side of the predecessor ("anterior") memory filled by the path-search core.
//  Starting at destino, walks the predecessor chain back to fonte and pushes every node into an internal LIFO.
//  Then streams the path out in fonte->destino order over a valid/ready interface.
//  Sits between gerenciador_memoria_anterior's memory port and the external path consumer.
// PARAMETERS
//  ADDR_WIDTH   9                         node address width
//  MAX_CAMINHO  64                        LIFO depth = max nodes in a path (fonte and destino included)
//  CNT_WIDTH    $clog2(MAX_CAMINHO+1)     LIFO occupancy / hop counter width
// PORTS
//  clk             in   1           single clock; all logic on posedge
//  rst_n           in   1           asynchronous, active-low reset
//  inicio_in       in   1           start pulse; sampled only in OCIOSO
//  fonte_in        in   ADDR_WIDTH  source node; latched on inicio_in
//  destino_in      in   ADDR_WIDTH  destination node; latched on inicio_in
//  mem_rd_en       out  1           predecessor memory read strobe
//  mem_rd_addr     out  ADDR_WIDTH  node whose predecessor is read
//  mem_rd_data     in   ADDR_WIDTH  predecessor; valid exactly 1 cycle after mem_rd_en
//  caminho_valid   out  1           path node available
//  caminho_ready   in   1           consumer accepts node when valid&ready
//  caminho_addr    out  ADDR_WIDTH  path node, fonte first
//  caminho_last    out  1           high with the destino node
//  ocupado         out  1           high in every state except OCIOSO
//  pronto          out  1           1-cycle pulse after the last node handshake
//  erro            out  1           1-cycle pulse on LIFO overflow abort
// BEHAVIOUR
//  Reset: all outputs 0, FSM=OCIOSO, LIFO count=0, latched fonte/destino=0.
//  FSM OCIOSO -> LER -> ESPERAR -> (LER | EMITIR | ERRO) ; EMITIR -> FIM -> OCIOSO ; ERRO -> OCIOSO.
//  OCIOSO: on inicio_in, latch fonte/destino, push destino (count=1), cur=destino.
//    If destino==fonte, go to EMITIR (1-node path); otherwise go to LER.
//  LER: mem_rd_en=1 for exactly one cycle, mem_rd_addr=cur; next state ESPERAR.
//  ESPERAR: capture mem_rd_data.
//    If count==MAX_CAMINHO: go to ERRO; push is dropped.
//    Else push, cur=mem_rd_data; if mem_rd_data==fonte go to EMITIR, else go to LER.
//    Each hop costs 2 cycles; an N-node path is fully read 2*(N-1) cycles after inicio_in.
//  EMITIR: caminho_addr=LIFO[count-1], caminho_valid=1.
//    caminho_last=(count==1).
//    On valid&ready: pop. If last, go to FIM.
//    addr and last are held stable while valid&!ready; valid never drops without a handshake.
//    Back-to-back pops are supported: one node per cycle while ready=1.
//  FIM: pronto=1 for one cycle, count=0, next state OCIOSO.
//  ERRO: erro=1 for one cycle, LIFO cleared, no caminho_valid issued, next state OCIOSO.
//  inicio_in is ignored outside OCIOSO; there is no queueing.
//  rst_n asserted mid-walk or mid-emit: immediate return to the reset state. A partial path is never resumed.
//  The LIFO is a register array. Data beyond count is don't-care; only count is reset.
//  Comparison cur==fonte uses the full ADDR_WIDTH; no arithmetic wrap is possible (count saturates by abort).
// CONFIGURATION
//  LEITOR_CAMINHO_TAMANHO_EN defined:
//    Adds output caminho_tamanho [CNT_WIDTH-1:0] = number of nodes in the path.
//    It is valid from entry to EMITIR until the next inicio_in. Reset 0; cleared to 0 on ERRO.
//  LEITOR_CAMINHO_TAMANHO_EN undefined: port and counter are absent. All other behaviour is identical.
// TESTING
//  T1 chain 7->5->2->0 (ant[7]=5, ant[5]=2, ant[2]=0), fonte=0, destino=7, ready=1:
//     -> 3 reads at addrs 7, 5, 2. Then emission 0, 2, 5, 7 on consecutive cycles, last on 7, then pronto.
//  T2 fonte=destino=12 -> no mem_rd_en; single node 12 with last=1; pronto; tamanho=1 if enabled.
//  T3 T1 with ready toggling 1,0,0,1,...
//     -> addr and last stable while stalled; exactly 4 handshakes; order unchanged.
//  T4 cyclic memory ant[3]=4, ant[4]=3, fonte=9, MAX_CAMINHO=64:
//     -> erro pulse once 64 nodes are held; no caminho_valid; returns to OCIOSO.
//  T5 rst_n low during ESPERAR of T1 -> all outputs 0 asynchronously.
//     A new inicio_in (fonte=0, destino=7) after release -> correct T1 output.
//  T6 inicio_in pulsed during EMITIR of T1 -> ignored; T1 path emitted intact, ocupado high until pronto.

Source files
------------

// File: rtl/leitor_caminho_anterior_if.sv
// Path stream interface: producer (master) presents nodes, consumer (slave) accepts on valid&ready.
interface leitor_caminho_anterior_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;

    modport master (output valid, output addr, output last, input ready);
    modport slave  (input valid, input addr, input last, output ready);
endinterface

// File: rtl/leitor_caminho_anterior.sv
// Walks the predecessor chain from destino back to fonte into a LIFO, then streams it fonte-first.
// Optional feature: LEITOR_CAMINHO_TAMANHO_EN adds the caminho_tamanho path-length output.
module leitor_caminho_anterior #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned MAX_CAMINHO = 64,
    parameter int unsigned CNT_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inicio_in,
    input  logic [ADDR_WIDTH-1:0]     fonte_in,
    input  logic [ADDR_WIDTH-1:0]     destino_in,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic [ADDR_WIDTH-1:0]     mem_rd_data,
    leitor_caminho_anterior_if.master caminho,
    output logic                      ocupado,
    output logic                      pronto,
    output logic                      erro
`ifdef LEITOR_CAMINHO_TAMANHO_EN
    ,
    output logic [CNT_WIDTH-1:0]      caminho_tamanho
`endif
);

    localparam int unsigned IDX_WIDTH = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_CAMINHO);

    typedef enum logic [2:0] {
        OCIOSO,
        LER,
        ESPERAR,
        EMITIR,
        FIM,
        ERRO
    } estado_t;

    estado_t               state;
    logic [CNT_WIDTH-1:0]  count;
    logic [ADDR_WIDTH-1:0] fonte;
    logic [ADDR_WIDTH-1:0] cur;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] lifo [MAX_CAMINHO];

    logic                  push_en_c;
    logic [IDX_WIDTH-1:0]  push_idx_c;
    logic [ADDR_WIDTH-1:0] push_data_c;
    logic [IDX_WIDTH-1:0]  pop_idx_c;

    assign mem_rd_addr   = cur;
    assign caminho.valid = valid_q;
    assign caminho.addr  = addr_q;
    assign caminho.last  = last_q;

    // LIFO write port: destino on start, each predecessor until the LIFO is full
    always_comb begin
        push_en_c   = 1'b0;
        push_idx_c  = IDX_WIDTH'(count);
        push_data_c = mem_rd_data;
        pop_idx_c   = IDX_WIDTH'(count - CNT_WIDTH'(2));
        if (state == OCIOSO && inicio_in) begin
            push_en_c   = 1'b1;
            push_idx_c  = '0;
            push_data_c = destino_in;
        end else if (state == ESPERAR && count != CNT_MAX) begin
            push_en_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en_c) lifo[push_idx_c] <= push_data_c;
    end

`ifdef LEITOR_CAMINHO_TAMANHO_EN
    logic [CNT_WIDTH-1:0] tamanho;
    assign caminho_tamanho = tamanho;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCIOSO;
            count     <= '0;
            fonte     <= '0;
            cur       <= '0;
            mem_rd_en <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
            tamanho   <= '0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
            unique case (state)
                OCIOSO: begin
                    if (inicio_in) begin
                        fonte   <= fonte_in;
                        cur     <= destino_in;
                        count   <= CNT_WIDTH'(1);
                        ocupado <= 1'b1;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
                        tamanho <= '0;
`endif
                        if (destino_in == fonte_in) begin
                            state   <= EMITIR;
                            valid_q <= 1'b1;
                            addr_q  <= destino_in;
                            last_q  <= 1'b1;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
                            tamanho <= CNT_WIDTH'(1);
`endif
                        end else begin
                            state     <= LER;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                LER: state <= ESPERAR;
                ESPERAR: begin
                    // A full LIFO means a cycle or an over-long path: abort instead of pushing
                    if (count == CNT_MAX) begin
                        state <= ERRO;
                        erro  <= 1'b1;
                        count <= '0;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
                        tamanho <= '0;
`endif
                    end else begin
                        count <= count + CNT_WIDTH'(1);
                        cur   <= mem_rd_data;
                        if (mem_rd_data == fonte) begin
                            state   <= EMITIR;
                            valid_q <= 1'b1;
                            addr_q  <= mem_rd_data;
                            last_q  <= 1'b0;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
                            tamanho <= count + CNT_WIDTH'(1);
`endif
                        end else begin
                            state     <= LER;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                EMITIR: begin
                    if (valid_q && caminho.ready) begin
                        count <= count - CNT_WIDTH'(1);
                        if (last_q) begin
                            state   <= FIM;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            pronto  <= 1'b1;
                        end else begin
                            addr_q <= lifo[pop_idx_c];
                            last_q <= (count == CNT_WIDTH'(2));
                        end
                    end
                end
                FIM: begin
                    count   <= '0;
                    ocupado <= 1'b0;
                    state   <= OCIOSO;
                end
                ERRO: begin
                    ocupado <= 1'b0;
                    state   <= OCIOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    state   <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leitor_caminho_anterior.sv
// Directed bench for leitor_caminho_anterior: predecessor memory model plus stream monitor.
module tb_leitor_caminho_anterior;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inicio = 1'b0;
    logic [AW-1:0] fonte = '0;
    logic [AW-1:0] destino = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_rd_data = '0;
    logic          ocupado, pronto, erro;
`ifdef LEITOR_CAMINHO_TAMANHO_EN
    logic [6:0]    tamanho;
`endif

    leitor_caminho_anterior_if #(.ADDR_WIDTH(AW)) cam ();

    leitor_caminho_anterior dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inicio_in   (inicio),
        .fonte_in    (fonte),
        .destino_in  (destino),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .caminho     (cam.master),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .erro        (erro)
`ifdef LEITOR_CAMINHO_TAMANHO_EN
        ,
        .caminho_tamanho (tamanho)
`endif
    );

    always #5 clk = ~clk;

    logic [AW-1:0] ant [512];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ant[mem_rd_addr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation state, sampled at negedge
    int            rd_q[$];
    int            hs_addr[$];
    int            hs_last[$];
    int            hs_cyc[$];
    int            pronto_cnt, erro_cnt, valid_cnt, stab_err;
    int            inicio_cyc, first_valid_cyc;
    bit            inicio_seen, valid_seen, prev_stall;
    logic [AW-1:0] prev_addr;
    logic          prev_last;

    always @(negedge clk) if (rst_n) begin
        if (mem_rd_en) rd_q.push_back(int'(mem_rd_addr));
        if (inicio && !inicio_seen) begin inicio_seen = 1; inicio_cyc = cyc; end
        if (cam.valid) begin
            valid_cnt++;
            if (!valid_seen) begin valid_seen = 1; first_valid_cyc = cyc; end
        end
        if (cam.valid && cam.ready) begin
            hs_addr.push_back(int'(cam.addr));
            hs_last.push_back(int'(cam.last));
            hs_cyc.push_back(cyc);
        end
        if (prev_stall && (!cam.valid || cam.addr !== prev_addr || cam.last !== prev_last)) stab_err++;
        prev_stall = cam.valid && !cam.ready;
        prev_addr  = cam.addr;
        prev_last  = cam.last;
        if (pronto) pronto_cnt++;
        if (erro) erro_cnt++;
    end

    task automatic clear_obs();
        rd_q.delete(); hs_addr.delete(); hs_last.delete(); hs_cyc.delete();
        pronto_cnt = 0; erro_cnt = 0; valid_cnt = 0; stab_err = 0;
        inicio_seen = 0; valid_seen = 0; prev_stall = 0;
        inicio_cyc = 0; first_valid_cyc = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) ant[i] = '0;
    endtask

    task automatic set_t1_mem();
        clear_mem();
        ant[7] = 9'd5; ant[5] = 9'd2; ant[2] = 9'd0;
    endtask

    task automatic start(input int f, input int d);
        @(posedge clk); #1;
        inicio = 1'b1; fonte = AW'(f); destino = AW'(d);
        @(posedge clk); #1;
        inicio = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        int base;
        base = pronto_cnt + erro_cnt;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (pronto_cnt + erro_cnt != base) begin to = 1'b0; break; end
        end
    endtask

    task automatic check_t1_path(input string tag);
        int exp_a[4];
        exp_a = '{0, 2, 5, 7};
        n_cmp++;
        if (hs_addr.size() !== 4) begin
            n_err++; $display("FAIL %s_hs_count got %0d want 4", tag, hs_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (hs_addr[i] !== exp_a[i] || hs_last[i] !== ((i == 3) ? 1 : 0)) begin
                    n_err++;
                    $display("FAIL %s_node%0d got addr=%0d last=%0d want addr=%0d last=%0d",
                             tag, i, hs_addr[i], hs_last[i], exp_a[i], (i == 3) ? 1 : 0);
                end
            end
        end
        n_cmp++;
        if (pronto_cnt !== 1) begin n_err++; $display("FAIL %s_pronto got %0d want 1", tag, pronto_cnt); end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({mem_rd_en, cam.valid, cam.last, ocupado, pronto, erro} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 000000",
                              {mem_rd_en, cam.valid, cam.last, ocupado, pronto, erro});
        end
        n_cmp++;
        if (mem_rd_addr !== '0 || cam.addr !== '0) begin
            n_err++; $display("FAIL reset_addr got rd=%0d cam=%0d want 0 0", mem_rd_addr, cam.addr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_chain();
        bit to;
        set_t1_mem(); clear_obs(); cam.ready = 1'b1;
        start(0, 7);
        wait_done(100, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t1_timeout got timeout want done"); end
        n_cmp++;
        if (rd_q.size() !== 3 || rd_q[0] !== 7 || rd_q[1] !== 5 || rd_q[2] !== 2) begin
            n_err++; $display("FAIL t1_reads got %p want 7 5 2", rd_q);
        end
        check_t1_path("t1");
        n_cmp++;
        if (hs_cyc.size() == 4 && (hs_cyc[1] != hs_cyc[0] + 1 || hs_cyc[3] != hs_cyc[0] + 3)) begin
            n_err++; $display("FAIL t1_back_to_back got cycles %p want consecutive", hs_cyc);
        end
        n_cmp++;
        if (first_valid_cyc - inicio_cyc !== 7) begin
            n_err++; $display("FAIL t1_latency got %0d want 7", first_valid_cyc - inicio_cyc);
        end
        n_cmp++;
        if (ocupado !== 1'b1) begin n_err++; $display("FAIL t1_ocupado_fim got %b want 1", ocupado); end
`ifdef LEITOR_CAMINHO_TAMANHO_EN
        n_cmp++;
        if (tamanho !== 7'd4) begin n_err++; $display("FAIL t1_tamanho got %0d want 4", tamanho); end
`endif
        @(negedge clk); #1;
        n_cmp++;
        if (ocupado !== 1'b0) begin n_err++; $display("FAIL t1_ocupado_idle got %b want 0", ocupado); end
    endtask

    task automatic test_single_node();
        bit to;
        clear_mem(); clear_obs(); cam.ready = 1'b1;
        start(12, 12);
        wait_done(20, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t2_timeout got timeout want done"); end
        n_cmp++;
        if (rd_q.size() !== 0) begin n_err++; $display("FAIL t2_reads got %0d want 0", rd_q.size()); end
        n_cmp++;
        if (hs_addr.size() !== 1 || hs_addr[0] !== 12 || hs_last[0] !== 1) begin
            n_err++; $display("FAIL t2_node got %p last %p want 12 last 1", hs_addr, hs_last);
        end
        n_cmp++;
        if (first_valid_cyc - inicio_cyc !== 1) begin
            n_err++; $display("FAIL t2_latency got %0d want 1", first_valid_cyc - inicio_cyc);
        end
`ifdef LEITOR_CAMINHO_TAMANHO_EN
        n_cmp++;
        if (tamanho !== 7'd1) begin n_err++; $display("FAIL t2_tamanho got %0d want 1", tamanho); end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        bit to;
        bit done;
        int pat[4];
        pat = '{1, 0, 0, 1};
        set_t1_mem(); clear_obs(); cam.ready = 1'b1;
        done = 1'b0;
        fork
            begin
                start(0, 7);
                wait_done(200, to);
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 220 && !done; i++) begin
                    @(posedge clk); #1;
                    cam.ready = pat[i % 4][0];
                end
            end
        join
        cam.ready = 1'b1;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t3_timeout got timeout want done"); end
        check_t1_path("t3");
        n_cmp++;
        if (stab_err !== 0) begin n_err++; $display("FAIL t3_stable got %0d violations want 0", stab_err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow();
        bit to;
        clear_mem(); clear_obs(); cam.ready = 1'b1;
        ant[3] = 9'd4; ant[4] = 9'd3;
        start(9, 3);
        wait_done(400, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t4_timeout got timeout want done"); end
        n_cmp++;
        if (erro_cnt !== 1 || pronto_cnt !== 0) begin
            n_err++; $display("FAIL t4_erro got erro=%0d pronto=%0d want 1 0", erro_cnt, pronto_cnt);
        end
        n_cmp++;
        if (valid_cnt !== 0) begin n_err++; $display("FAIL t4_no_valid got %0d want 0", valid_cnt); end
        n_cmp++;
        if (rd_q.size() !== 64) begin n_err++; $display("FAIL t4_reads got %0d want 64", rd_q.size()); end
        @(negedge clk); #1;
        n_cmp++;
        if (ocupado !== 1'b0 || erro !== 1'b0) begin
            n_err++; $display("FAIL t4_idle got ocupado=%b erro=%b want 0 0", ocupado, erro);
        end
`ifdef LEITOR_CAMINHO_TAMANHO_EN
        n_cmp++;
        if (tamanho !== 7'd0) begin n_err++; $display("FAIL t4_tamanho got %0d want 0", tamanho); end
`endif
    endtask

    task automatic test_reset_mid_walk();
        bit to;
        bit seen;
        set_t1_mem(); clear_obs(); cam.ready = 1'b1;
        start(0, 7);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_rd_en;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_rd_en, cam.valid, cam.last, ocupado, pronto, erro} !== 6'b0 || mem_rd_addr !== '0) begin
            n_err++; $display("FAIL t5_async_reset got ctrl=%b rd_addr=%0d want 0 0",
                              {mem_rd_en, cam.valid, cam.last, ocupado, pronto, erro}, mem_rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_obs();
        start(0, 7);
        wait_done(100, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t5_timeout got timeout want done"); end
        check_t1_path("t5");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        bit to;
        bit seen;
        set_t1_mem(); clear_obs(); cam.ready = 1'b1;
        start(0, 7);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cam.valid;
        end
        @(posedge clk); #1;
        inicio = 1'b1; fonte = 9'd12; destino = 9'd12;
        @(posedge clk); #1;
        inicio = 1'b0;
        wait_done(100, to);
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL t6_timeout got timeout want done"); end
        check_t1_path("t6");
        repeat (6) @(negedge clk);
        n_cmp++;
        if (hs_addr.size() !== 4 || rd_q.size() !== 3 || ocupado !== 1'b0) begin
            n_err++; $display("FAIL t6_ignored got hs=%0d rd=%0d ocupado=%b want 4 3 0",
                              hs_addr.size(), rd_q.size(), ocupado);
        end
    endtask

    initial begin
        cam.ready = 1'b1;
        clear_mem();
        clear_obs();
        test_reset();
        test_chain();
        test_single_node();
        test_stall();
        test_overflow();
        test_reset_mid_walk();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
